cpu_ram_arbiter: RTL and testbench

- Shares the single-port `cpu_ram` data path between the CPU instruction (I) and data (D) requesters.
- Each requester uses the `cpu_ram` req/valid handshake: one-cycle `req` pulse, request fields held stable until `valid`.
- The arbiter queues pending pulses, grants one port at a time and forwards the RAM response to the granted port.
- Sits between the CPU core and a single RAM instance in the SoC top.

---
 rtl/cpu_ram_arbiter.sv | 167 ++++++++++++++++
 tb/tb_cpu_ram_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ram_arbiter.sv
// Two-requester (instruction/data) arbiter in front of the single-port cpu_ram.
// Define CPU_RAM_ARB_ROUND_ROBIN_EN for round-robin on contention; default is fixed D priority.
module cpu_ram_arbiter #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_valid,
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                m_req,
  output logic [ADDR_W-1:0]   m_addr,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_valid
);

  localparam int unsigned BeW = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StWaitI, StWaitD} state_e;

  state_e              state_q, state_d;
  logic                pend_i_q, pend_i_d, pend_d_q, pend_d_d;
  logic                m_req_q, m_req_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic                m_we_q, m_we_d;
  logic [BeW-1:0]      m_be_q, m_be_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic                eff_i, eff_d, grant_i, grant_d;
  logic                i_inflight, d_inflight;

  assign eff_i = i_req | pend_i_q;
  assign eff_d = d_req | pend_d_q;

  // A port still waiting for its own completion cannot queue another request.
  assign i_inflight = (state_q == StWaitI) && !m_valid;
  assign d_inflight = (state_q == StWaitD) && !m_valid;

`ifdef CPU_RAM_ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;  // 1: most recent grant went to D

  always_comb begin
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    last_d_d = last_d_q;
    if (state_q == StIdle) begin
      if (eff_i && eff_d) begin
        grant_i = last_d_q;
        grant_d = !last_d_q;
      end else begin
        grant_i = eff_i;
        grant_d = eff_d;
      end
    end
    if (grant_d) begin
      last_d_d = 1'b1;
    end else if (grant_i) begin
      last_d_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_d_q <= 1'b1;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`else
  always_comb begin
    grant_d = (state_q == StIdle) && eff_d;
    grant_i = (state_q == StIdle) && eff_i && !eff_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    m_req_d   = 1'b0;
    m_addr_d  = m_addr_q;
    m_we_d    = m_we_q;
    m_be_d    = m_be_q;
    m_wdata_d = m_wdata_q;
    pend_i_d  = grant_i ? 1'b0 : (pend_i_q | (i_req & !i_inflight));
    pend_d_d  = grant_d ? 1'b0 : (pend_d_q | (d_req & !d_inflight));
    case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d   = StWaitD;
          m_req_d   = 1'b1;
          m_addr_d  = d_addr;
          m_we_d    = d_we;
          m_be_d    = d_be;
          m_wdata_d = d_wdata;
        end else if (grant_i) begin
          state_d   = StWaitI;
          m_req_d   = 1'b1;
          m_addr_d  = i_addr;
          m_we_d    = 1'b0;
          m_be_d    = '0;
          m_wdata_d = '0;
        end
      end
      StWaitI, StWaitD: begin
        if (m_valid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      pend_i_q  <= 1'b0;
      pend_d_q  <= 1'b0;
      m_req_q   <= 1'b0;
      m_addr_q  <= '0;
      m_we_q    <= 1'b0;
      m_be_q    <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_i_q  <= pend_i_d;
      pend_d_q  <= pend_d_d;
      m_req_q   <= m_req_d;
      m_addr_q  <= m_addr_d;
      m_we_q    <= m_we_d;
      m_be_q    <= m_be_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_addr  = m_addr_q;
  assign m_we    = m_we_q;
  assign m_be    = m_be_q;
  assign m_wdata = m_wdata_q;

  assign i_valid = m_valid && (state_q == StWaitI);
  assign d_valid = m_valid && (state_q == StWaitD);
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_n && i_req && (pend_i_q || i_inflight)) begin
      $error("cpu_ram_arbiter: i_req while I request outstanding");
    end
    if (reset_n && d_req && (pend_d_q || d_inflight)) begin
      $error("cpu_ram_arbiter: d_req while D request outstanding");
    end
  end
`endif

endmodule

// File: tb/tb_cpu_ram_arbiter.sv
// Self-checking bench for cpu_ram_arbiter: RAM model, per-port expectation queues,
// grant-order log and a random hammer with random RAM latency.
module tb_cpu_ram_arbiter;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic        we;
    logic [31:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_valid;
  logic          d_req = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic          d_we = 1'b0;
  logic [3:0]    d_be = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          m_req;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [3:0]    m_be;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;
  logic          m_valid = 1'b0;

  cpu_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_valid (i_valid),
    .d_req   (d_req),
    .d_addr  (d_addr),
    .d_we    (d_we),
    .d_be    (d_be),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_valid (d_valid),
    .m_req   (m_req),
    .m_addr  (m_addr),
    .m_we    (m_we),
    .m_be    (m_be),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_valid (m_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  logic [31:0] ram_mem [8192];
  logic [31:0] shadow [8192];
  exp_t        exp_i[$];
  exp_t        exp_d[$];
  logic [14:0] grant_log[$];
  int          i_issued = 0, i_done = 0, d_issued = 0, d_done = 0;
  int          mreq_cnt = 0;
  int          ram_lat_fix = 2;
  logic        ram_busy = 1'b0;
  logic        prev_mreq = 1'b0, prev_iv = 1'b0, prev_dv = 1'b0;
  logic [12:0] i_word = '0, d_word = '0;

  initial begin
    for (int k = 0; k < 8192; k++) begin
      ram_mem[k] = '0;
      shadow[k]  = '0;
    end
  end

  // RAM model: captures on the m_req cycle, answers after a 1-5 cycle latency.
  always begin
    @(posedge clk);
    #1;
    if (m_req && reset_n) begin
      logic [12:0] w;
      logic [31:0] rd;
      int          lat;
      ram_busy = 1'b1;
      w  = m_addr[14:2];
      rd = ram_mem[w];
      if (m_we) begin
        for (int b = 0; b < 4; b++) begin
          if (m_be[b]) ram_mem[w][8*b +: 8] = m_wdata[8*b +: 8];
        end
      end
      lat = (ram_lat_fix != 0) ? ram_lat_fix : int'($urandom_range(1, 5));
      repeat (lat) @(posedge clk);
      #1;
      m_valid = 1'b1;
      m_rdata = rd;
      @(posedge clk);
      #1;
      m_valid  = 1'b0;
      ram_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (m_req) begin
        check_eq("m_req_single_cycle", 32'(prev_mreq), 32'd0);
        mreq_cnt++;
        grant_log.push_back(m_addr);
      end
      if (i_valid) begin
        check_eq("i_valid_single_cycle", 32'(prev_iv), 32'd0);
        if (exp_i.size() == 0) begin
          check_eq("i_valid_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_i.pop_front();
          check_eq("i_rdata", i_rdata, e.data);
          i_done++;
        end
      end
      if (d_valid) begin
        check_eq("d_valid_single_cycle", 32'(prev_dv), 32'd0);
        if (exp_d.size() == 0) begin
          check_eq("d_valid_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_d.pop_front();
          if (!e.we) check_eq("d_rdata", d_rdata, e.data);
          d_done++;
        end
      end
    end
    prev_mreq = m_req && reset_n;
    prev_iv   = i_valid && reset_n;
    prev_dv   = d_valid && reset_n;
  end

  task automatic issue_i(input logic [14:0] a);
    exp_t e;
    i_addr = a;
    i_req  = 1'b1;
    e.we   = 1'b0;
    e.data = shadow[a[14:2]];
    exp_i.push_back(e);
    i_word = a[14:2];
    i_issued++;
  endtask

  task automatic issue_d(input logic [14:0] a, input logic we, input logic [3:0] be,
                         input logic [31:0] wd);
    exp_t e;
    d_addr  = a;
    d_we    = we;
    d_be    = be;
    d_wdata = wd;
    d_req   = 1'b1;
    e.we    = we;
    e.data  = shadow[a[14:2]];
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) shadow[a[14:2]][8*b +: 8] = wd[8*b +: 8];
      end
    end
    exp_d.push_back(e);
    d_word = a[14:2];
    d_issued++;
  endtask

  task automatic wait_quiet(input string tag);
    int n = 0;
    while ((i_issued != i_done || d_issued != d_done || ram_busy) && n < 500) begin
      @(posedge clk);
      n++;
    end
    check_eq(tag, 32'(n >= 500), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    exp_i.delete();
    exp_d.delete();
    i_issued = i_done;
    d_issued = d_done;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  logic [31:0] lcg_i = 32'h1234_5678;
  logic [31:0] lcg_d = 32'h0bad_cafe;

  initial begin
    int base_i, base_d, base_m;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_m_req", 32'(m_req), 32'd0);
    check_eq("rst_m_addr", 32'(m_addr), 32'd0);
    check_eq("rst_m_we", 32'(m_we), 32'd0);
    check_eq("rst_m_be", 32'(m_be), 32'd0);
    check_eq("rst_m_wdata", m_wdata, 32'd0);
    check_eq("rst_i_valid", 32'(i_valid), 32'd0);
    check_eq("rst_d_valid", 32'(d_valid), 32'd0);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("idle_no_m_req", 32'(mreq_cnt), 32'd0);

    // Single D write
    base_i = i_done;
    issue_d(15'h0010, 1'b1, 4'hf, 32'hdead_beef);
    @(posedge clk);
    #1;
    d_req = 1'b0;
    @(negedge clk);
    check_eq("wr_m_req", 32'(m_req), 32'd1);
    check_eq("wr_m_addr", 32'(m_addr), 32'h10);
    check_eq("wr_m_we", 32'(m_we), 32'd1);
    check_eq("wr_m_be", 32'(m_be), 32'hf);
    check_eq("wr_m_wdata", m_wdata, 32'hdead_beef);
    @(negedge clk);
    check_eq("wr_m_req_drop", 32'(m_req), 32'd0);
    wait_quiet("wr_timeout");
    check_eq("wr_d_done", 32'(d_done), 32'(d_issued));
    check_eq("wr_no_i_valid", 32'(i_done - base_i), 32'd0);

    // Read back via I then D
    issue_i(15'h0010);
    @(posedge clk);
    #1;
    i_req = 1'b0;
    wait_quiet("rdi_timeout");
    issue_d(15'h0010, 1'b0, 4'hf, 32'd0);
    @(posedge clk);
    #1;
    d_req = 1'b0;
    wait_quiet("rdd_timeout");
    check_eq("rdback_counts", 32'(i_done + d_done), 32'(i_issued + d_issued));

    // Simultaneous requests straight after reset (last grant = D)
    apply_reset();
    @(posedge clk);
    #1;
    grant_log.delete();
    issue_i(15'h0004);
    issue_d(15'h0008, 1'b0, 4'hf, 32'd0);
    @(posedge clk);
    #1;
    i_req = 1'b0;
    d_req = 1'b0;
    wait_quiet("sim_timeout");
    check_eq("sim_grant_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
`ifdef CPU_RAM_ARB_ROUND_ROBIN_EN
      check_eq("sim_first", 32'(grant_log[0]), 32'h4);
      check_eq("sim_second", 32'(grant_log[1]), 32'h8);
`else
      check_eq("sim_first", 32'(grant_log[0]), 32'h8);
      check_eq("sim_second", 32'(grant_log[1]), 32'h4);
`endif
    end

    // Hammer: concurrent random I reads and D reads/writes, random RAM latency
    ram_lat_fix = 0;
    fork
      begin
        for (int k = 0; k < 200; k++) begin
          logic [12:0] w;
          int n;
          repeat ($urandom_range(0, 3)) @(posedge clk);
          @(posedge clk);
          #1;
          do begin
            lcg_i = lcg_i * 32'd1103515245 + 32'd12345;
            w = lcg_i[16] ? {8'h10, lcg_i[21:17]} : lcg_i[29:17];
          end while (d_issued != d_done && w == d_word);
          issue_i({w, 2'b00});
          @(posedge clk);
          #1;
          i_req = 1'b0;
          n = 0;
          while (i_issued != i_done && n < 300) begin
            @(posedge clk);
            n++;
          end
          if (n >= 300) check_eq("ham_i_timeout", 32'd1, 32'd0);
        end
      end
      begin
        for (int k = 0; k < 200; k++) begin
          logic [12:0] w;
          int n;
          repeat ($urandom_range(0, 3)) @(posedge clk);
          @(posedge clk);
          #2;
          do begin
            lcg_d = lcg_d * 32'd1103515245 + 32'd12345;
            w = lcg_d[16] ? {8'h10, lcg_d[21:17]} : lcg_d[29:17];
          end while (i_issued != i_done && w == i_word);
          issue_d({w, 2'b00}, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom);
          @(posedge clk);
          #2;
          d_req = 1'b0;
          n = 0;
          while (d_issued != d_done && n < 300) begin
            @(posedge clk);
            n++;
          end
          if (n >= 300) check_eq("ham_d_timeout", 32'd1, 32'd0);
        end
      end
    join
    wait_quiet("ham_timeout");
    check_eq("ham_i_count", 32'(i_done), 32'(i_issued));
    check_eq("ham_d_count", 32'(d_done), 32'(d_issued));

    // Reset while D is in flight and I is pending
    ram_lat_fix = 5;
    base_m = mreq_cnt;
    issue_d(15'h0020, 1'b0, 4'hf, 32'd0);
    @(posedge clk);
    #1;
    d_req = 1'b0;
    issue_i(15'h0010);
    @(posedge clk);
    #1;
    i_req = 1'b0;
    apply_reset();
    base_i = i_done;
    base_d = d_done;
    repeat (12) @(posedge clk);
    #1;
    check_eq("abort_no_i_valid", 32'(i_done - base_i), 32'd0);
    check_eq("abort_no_d_valid", 32'(d_done - base_d), 32'd0);
    check_eq("abort_single_grant", 32'(mreq_cnt - base_m), 32'd1);
    ram_lat_fix = 2;
    issue_i(15'h0010);
    @(posedge clk);
    #1;
    i_req = 1'b0;
    wait_quiet("post_rst_timeout");
    check_eq("post_rst_i_served", 32'(i_done - base_i), 32'd1);
    check_eq("final_exp_i_empty", 32'(exp_i.size()), 32'd0);
    check_eq("final_exp_d_empty", 32'(exp_d.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
